// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB, LU and register-file write-port signals of the writeback stage
interface wb_stage_if #(
    parameter int DW = 19,
    parameter int RW = 3
);
    logic          MEM_valid;
    logic          MEM_regwrite;
    logic          MEM_memtoreg;
    logic [RW-1:0] MEM_rd;
    logic [DW-1:0] MEM_alu;
    logic [DW-1:0] MEM_rdata;
    logic          LU_valid;
    logic [RW-1:0] LU_rd;
    logic [DW-1:0] LU_data;
    logic          LU_ready;
    logic          WB_stall;
    logic          WB_regwrite;
    logic [RW-1:0] ws;
    logic [DW-1:0] wd;
    logic [7:0]    busy_mask;

    modport slave (
        input  MEM_valid, MEM_regwrite, MEM_memtoreg, MEM_rd, MEM_alu, MEM_rdata,
        input  LU_valid, LU_rd, LU_data,
        output LU_ready, WB_stall, WB_regwrite, ws, wd, busy_mask
    );

    modport master (
        output MEM_valid, MEM_regwrite, MEM_memtoreg, MEM_rd, MEM_alu, MEM_rdata,
        output LU_valid, LU_rd, LU_data,
        input  LU_ready, WB_stall, WB_regwrite, ws, wd, busy_mask
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: merges MEM/WB and buffered long-latency results onto one register-file write port
module wb_stage #(
    parameter int DW = 19,
    parameter int RW = 3
) (
    input logic        clk,
    input logic        reset,
    wb_stage_if.slave  bus
);
    localparam int DEPTH = 2;

    logic [RW-1:0] f_rd   [DEPTH];
    logic [DW-1:0] f_data [DEPTH];
    logic          head, tail;
    logic [1:0]    count;
    logic [1:0]    v;
    logic          mw, hit, conflict, enq, deq, wr_en;
    logic [RW-1:0] wr_rd;
    logic [DW-1:0] wr_data;
    logic [7:0]    mask;

    // FIFO occupancy, hazard detection and write-source selection
    always_comb begin
        v[0]     = (count == 2'd2) | ((count == 2'd1) & ~head);
        v[1]     = (count == 2'd2) | ((count == 2'd1) & head);
        mw       = bus.MEM_valid & bus.MEM_regwrite;
        hit      = (v[0] & (f_rd[0] == bus.MEM_rd)) | (v[1] & (f_rd[1] == bus.MEM_rd));
        conflict = mw & ((count == 2'd2) | hit);
        enq      = bus.LU_valid & (count < 2'd2);
        deq      = conflict | (~mw & (count != 2'd0));
        wr_en    = deq | mw;
        wr_rd    = deq ? f_rd[head] : bus.MEM_rd;
        wr_data  = deq ? f_data[head] : (bus.MEM_memtoreg ? bus.MEM_rdata : bus.MEM_alu);
        mask     = (v[0] ? (8'b1 << f_rd[0]) : 8'b0) | (v[1] ? (8'b1 << f_rd[1]) : 8'b0);
    end

    assign bus.LU_ready  = count < 2'd2;
    assign bus.WB_stall  = conflict;
    assign bus.busy_mask = mask;

    // FIFO storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            f_rd[tail]   <= bus.LU_rd;
            f_data[tail] <= bus.LU_data;
        end
    end

    // Pointers, occupancy and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= 1'b0;
            tail            <= 1'b0;
            count           <= 2'd0;
            bus.WB_regwrite <= 1'b0;
            bus.ws          <= '0;
            bus.wd          <= '0;
        end else begin
            tail            <= tail + enq;
            head            <= head + deq;
            count           <= count + {1'b0, enq} - {1'b0, deq};
            bus.WB_regwrite <= wr_en;
            if (wr_en) begin
                bus.ws <= wr_rd;
                bus.wd <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of writeback merging, LU FIFO, hazards and reset
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    wb_stage_if #(.DW(19), .RW(3)) bus ();

    wb_stage #(.DW(19), .RW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic valid, input logic rw, input logic m2r,
                       input logic [2:0] rd, input logic [18:0] alu, input logic [18:0] rdata);
        bus.MEM_valid    = valid;
        bus.MEM_regwrite = rw;
        bus.MEM_memtoreg = m2r;
        bus.MEM_rd       = rd;
        bus.MEM_alu      = alu;
        bus.MEM_rdata    = rdata;
    endtask

    task automatic lu(input logic valid, input logic [2:0] rd, input logic [18:0] data);
        bus.LU_valid = valid;
        bus.LU_rd    = rd;
        bus.LU_data  = data;
    endtask

    task automatic wr(input string tag, input logic en, input logic [2:0] rd, input logic [18:0] data);
        chk({tag, ".we"}, 32'(bus.WB_regwrite), 32'(en));
        chk({tag, ".ws"}, 32'(bus.ws), 32'(rd));
        chk({tag, ".wd"}, 32'(bus.wd), 32'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem(0, 0, 0, 3'd0, 19'h0, 19'h0);
        lu(0, 3'd0, 19'h0);
        reset = 1'b1;
        tick;
        tick;
        wr("rst", 0, 3'd0, 19'h0);
        chk("rst.ready", 32'(bus.LU_ready), 32'd1);
        chk("rst.busy", 32'(bus.busy_mask), 32'h00);
        chk("rst.stall", 32'(bus.WB_stall), 32'd0);
        reset = 1'b0;

        mem(1, 1, 0, 3'd3, 19'h12345, 19'h0);
        #1 chk("mem.stall", 32'(bus.WB_stall), 32'd0);
        tick;
        wr("mem_alu", 1, 3'd3, 19'h12345);
        mem(1, 1, 1, 3'd3, 19'h0, 19'h7FFFF);
        tick;
        wr("mem_load", 1, 3'd3, 19'h7FFFF);
        mem(0, 0, 0, 3'd0, 19'h0, 19'h0);
        tick;
        wr("idle_hold", 0, 3'd3, 19'h7FFFF);

        lu(1, 3'd5, 19'h00AAA);
        #1 chk("lu.ready", 32'(bus.LU_ready), 32'd1);
        chk("lu.busy_pre", 32'(bus.busy_mask), 32'h00);
        tick;
        lu(0, 3'd0, 19'h0);
        chk("lu.busy", 32'(bus.busy_mask), 32'h20);
        chk("lu.nowr", 32'(bus.WB_regwrite), 32'd0);
        tick;
        wr("lu_wr", 1, 3'd5, 19'h00AAA);
        chk("lu.busy_clr", 32'(bus.busy_mask), 32'h00);
        tick;
        chk("lu.once", 32'(bus.WB_regwrite), 32'd0);

        mem(1, 1, 0, 3'd4, 19'h00040, 19'h0);
        lu(1, 3'd1, 19'h00001);
        tick;
        wr("full.m40", 1, 3'd4, 19'h00040);
        mem(1, 1, 0, 3'd4, 19'h00041, 19'h0);
        lu(1, 3'd2, 19'h00002);
        #1 chk("full.nostall1", 32'(bus.WB_stall), 32'd0);
        tick;
        wr("full.m41", 1, 3'd4, 19'h00041);
        mem(1, 1, 0, 3'd4, 19'h00042, 19'h0);
        lu(0, 3'd0, 19'h0);
        #1 chk("full.ready", 32'(bus.LU_ready), 32'd0);
        chk("full.stall", 32'(bus.WB_stall), 32'd1);
        chk("full.busy", 32'(bus.busy_mask), 32'h06);
        tick;
        wr("full.r1", 1, 3'd1, 19'h00001);
        lu(1, 3'd7, 19'h00007);
        #1 chk("full.nostall2", 32'(bus.WB_stall), 32'd0);
        tick;
        wr("full.m42", 1, 3'd4, 19'h00042);
        mem(1, 1, 0, 3'd4, 19'h00043, 19'h0);
        lu(0, 3'd0, 19'h0);
        #1 chk("full.stall2", 32'(bus.WB_stall), 32'd1);
        chk("full.busy2", 32'(bus.busy_mask), 32'h84);
        tick;
        wr("full.r2", 1, 3'd2, 19'h00002);
        tick;
        wr("full.m43", 1, 3'd4, 19'h00043);
        mem(0, 0, 0, 3'd0, 19'h0, 19'h0);
        tick;
        wr("full.r7", 1, 3'd7, 19'h00007);
        chk("full.busy_clr", 32'(bus.busy_mask), 32'h00);

        lu(1, 3'd6, 19'h00111);
        tick;
        lu(0, 3'd0, 19'h0);
        mem(1, 1, 0, 3'd6, 19'h00222, 19'h0);
        #1 chk("haz.stall", 32'(bus.WB_stall), 32'd1);
        chk("haz.busy", 32'(bus.busy_mask), 32'h40);
        tick;
        wr("haz.old", 1, 3'd6, 19'h00111);
        chk("haz.nostall", 32'(bus.WB_stall), 32'd0);
        tick;
        wr("haz.new", 1, 3'd6, 19'h00222);

        mem(1, 1, 0, 3'd4, 19'h00050, 19'h0);
        lu(1, 3'd1, 19'h00011);
        tick;
        mem(1, 1, 0, 3'd4, 19'h00051, 19'h0);
        lu(1, 3'd2, 19'h00022);
        tick;
        wr("rmid.m51", 1, 3'd4, 19'h00051);
        chk("rmid.busy", 32'(bus.busy_mask), 32'h06);
        mem(1, 1, 0, 3'd4, 19'h00052, 19'h0);
        lu(1, 3'd3, 19'h00033);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mem(0, 0, 0, 3'd0, 19'h0, 19'h0);
        lu(0, 3'd0, 19'h0);
        #1 wr("rmid.rst", 0, 3'd0, 19'h0);
        chk("rmid.busy0", 32'(bus.busy_mask), 32'h00);
        chk("rmid.ready", 32'(bus.LU_ready), 32'd1);
        tick;
        chk("rmid.nostale1", 32'(bus.WB_regwrite), 32'd0);
        tick;
        chk("rmid.nostale2", 32'(bus.WB_regwrite), 32'd0);

        mem(1, 1, 0, 3'd0, 19'h01234, 19'h0);
        tick;
        wr("r0", 1, 3'd0, 19'h01234);
        mem(0, 0, 0, 3'd0, 19'h0, 19'h0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 19-bit pipelined CPU and the write-side driver of the register file. It merges results from two sources: the in-order MEM/WB pipeline, and out-of-order results from the long-latency custom unit (LU). It presents at most one register write per cycle on the register file's `WB_regwrite` / `ws` / `wd` port. LU results are buffered in a 2-entry FIFO, and a pending-destination mask is exported so ID can detect hazards.

## Interface
Parameters:
- `DW`, default 19: datapath width.
- `RW`, default 3: register index width (8 registers).
- `DEPTH`, fixed at 2: LU result FIFO depth. It is not overridable.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `MEM_valid`, input, 1: an instruction is present in MEM/WB.
- `MEM_regwrite`, input, 1: that instruction writes a register.
- `MEM_memtoreg`, input, 1: 1 selects `MEM_rdata`, 0 selects `MEM_alu`.
- `MEM_rd`, input, RW: destination register.
- `MEM_alu`, input, DW: ALU result.
- `MEM_rdata`, input, DW: load data.
- `LU_valid`, input, 1: LU offers a result.
- `LU_rd`, input, RW: LU destination register.
- `LU_data`, input, DW: LU result.
- `LU_ready`, output, 1: FIFO accepts an LU result this cycle.
- `WB_stall`, output, 1: combinational. When high, MEM/WB must hold its instruction.
- `WB_regwrite`, output, 1: registered write strobe to the register file.
- `ws`, output, RW: registered write index.
- `wd`, output, DW: registered write data.
- `busy_mask`, output, 8: bit n is set while any valid FIFO entry targets rn.

## Operation
- The FIFO holds `{rd, data}` entries with head/tail pointers and a 2-bit `count` (0..2). Pointers wrap modulo 2.
- `LU_ready` = (`count` < 2). It is derived from state only and does not depend on this cycle's dequeue.
- Enqueue happens when `LU_valid` and `LU_ready` are both high. A simultaneous enqueue and dequeue leaves `count` unchanged.
- Definitions used below:
  - `mw` = `MEM_valid` & `MEM_regwrite`.
  - `hit` = `MEM_rd` matches the rd of any valid FIFO entry.
  - `conflict` = `mw` & (`count`==2 | `hit`).
- Per-cycle write selection, in priority order:
  1. `conflict`: write the FIFO head, dequeue it, and assert `WB_stall`. The MEM instruction is not consumed.
  2. `mw`: write the MEM result (`MEM_memtoreg` selects the data). The MEM instruction is consumed.
  3. `count`>0: write the FIFO head and dequeue it. This applies when MEM is idle, or when MEM is valid with `MEM_regwrite`=0; in the latter case MEM is consumed with no write.
  4. Otherwise there is no write.
- `WB_stall` is 0 in every case except case 1.
- A `hit` forces the older LU result to retire before the younger MEM write to the same register, which preserves program-order final values.
- The `count`==2 case bounds LU starvation: with both entries full and MEM writing back-to-back, one stall cycle occurs per drained entry.
- r0 is an ordinary register; writes to r0 are performed.
- `busy_mask` is combinational from FIFO state and excludes the entry being enqueued this cycle.
- Widths: `wd` is exactly DW. No extension or truncation is applied.

## Timing
- The selected write appears on `WB_regwrite`/`ws`/`wd` on the cycle after selection, for exactly one cycle.
- When no write is selected, `WB_regwrite`=0 and `ws`/`wd` hold their previous values.
- Latency:
  - MEM to register-file write strobe: 1 cycle.
  - LU accept to write strobe: at least 2 cycles. There is no bypass from `LU_data` straight to `wd`.
- An entry enqueued at edge k is visible in `busy_mask` and eligible for drain in cycle k+1.
- After reset: `WB_regwrite`=0, `ws`=0, `wd`=0, `count`=0, `LU_ready`=1, `busy_mask`=0, `WB_stall`=0.
- Reset mid-operation: pending FIFO entries are discarded, no write is issued in the cycle after reset, and any LU handshake in the reset cycle is ignored.

## Test plan
- Reset: assert `reset` for 2 cycles, then release. Required: all outputs at reset values; `LU_ready`=1; `busy_mask`=8'h00.
- MEM writeback:
  - `MEM_valid`=1, `MEM_regwrite`=1, rd=3, `MEM_alu`=19'h12345, `MEM_memtoreg`=0. Next cycle: `WB_regwrite`=1, `ws`=3, `wd`=19'h12345.
  - Repeat with `MEM_memtoreg`=1 and `MEM_rdata`=19'h7FFFF. Required: `wd`=19'h7FFFF.
- LU path: `LU_valid` with rd=5, data=19'h00AAA, MEM idle. Required:
  - `busy_mask`=8'h20 in cycle+1.
  - Write of `ws`=5, `wd`=19'h00AAA at cycle+2.
  - `busy_mask` returns to 8'h00.
- Full FIFO: enqueue LU rd=1, then rd=2, while MEM writes rd=4 every cycle. Required:
  - When `count`==2: `LU_ready`=0 and `WB_stall`=1.
  - r1 is written, then r2 (with a stall each), and MEM rd=4 writes resume afterwards.
  - No MEM write is lost.
- Hazard ordering: FIFO holds rd=6, data=19'h00111, and MEM writes rd=6, data=19'h00222. Required:
  - Stall cycle writes r6=19'h00111.
  - The following cycle writes r6=19'h00222.
- Reset mid-operation: with 2 entries pending, pulse `reset`. Required:
  - `count`=0 and `busy_mask`=0 next cycle.
  - No stale LU write appears.
